mem_stage_lsu: RTL

Memory-stage load/store unit for the pipelined MIPS core. It sits between the EX/MEM pipeline register and the word-addressed data memory, and converts byte addresses and sub-word ops (lb/lbu/lh/lhu/lw/sb/sh/sw) into whole-word memory accesses. Loads are sign- or zero-extended and registered toward MEM/WB. Sub-word stores use a two-cycle read-modify-write, during which the unit stalls upstream.

---
 rtl/mips_mem_pkg.sv | 37 +++
 rtl/lsu_align.sv | 57 +++++
 rtl/mem_stage_lsu.sv | 116 +++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op codes, memory depth
// default and FSM state encoding.
package mips_mem_pkg;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    localparam int MEM_WORDS_DEF = 64;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_RMW_WR = 1'b1;

    function automatic logic op_is_load(input logic [2:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic op_is_sub_store(input logic [2:0] op);
        return (op == OP_SB) || (op == OP_SH);
    endfunction

    // Misalignment of halfword/word ops; byte ops are never misaligned.
    function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] a);
        case (op)
            OP_LH, OP_LHU, OP_SH: return a[0];
            OP_LW, OP_SW:         return a != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: extracts/extends load values from a memory word and
// builds the merged word for sub-word stores (little-endian).
module lsu_align
    import mips_mem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        case (op)
            OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_val = {24'd0, byte_sel};
            OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_val = {16'd0, half_sel};
            default: load_val = word;
        endcase
    end

    always_comb begin
        store_word = word;
        case (op)
            OP_SB: begin
                case (addr)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    default: store_word[31:24] = wdata[7:0];
                endcase
            end
            OP_SH: begin
                if (addr[1]) store_word[31:16] = wdata[15:0];
                else         store_word[15:0]  = wdata[15:0];
            end
            OP_SW:   store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: word-addressed memory access, registered loads,
// two-cycle read-modify-write for SB/SH, and fault detection.
module mem_stage_lsu
    import mips_mem_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic [4:0]  load_rd,
    output logic        fault,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writeData,
    input  logic [31:0] mem_readData
);

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS) << 2;

    logic        state;
    logic [31:0] merge_word;
    logic [31:0] merge_addr;

    logic        in_idle;
    logic        fault_c;
    logic        acc;
    logic        acc_load;
    logic        acc_sub;
    logic        acc_sw;
    logic [31:0] word_idx;
    logic [31:0] load_val;
    logic [31:0] store_word;

    assign word_idx = {2'b00, req_addr[31:2]};

    lsu_align u_align (
        .op         (req_op),
        .addr       (req_addr[1:0]),
        .word       (mem_readData),
        .wdata      (req_wdata),
        .load_val   (load_val),
        .store_word (store_word)
    );

    always_comb begin
        in_idle  = (state == ST_IDLE);
        fault_c  = req_valid && in_idle &&
                   (op_misaligned(req_op, req_addr[1:0]) || (req_addr >= ADDR_LIMIT));
        acc      = req_valid && in_idle && !fault_c;
        acc_load = acc && op_is_load(req_op);
        acc_sub  = acc && op_is_sub_store(req_op);
        acc_sw   = acc && (req_op == OP_SW);
    end

    // The RMW write cycle overrides whatever is on req_*; upstream is held.
    always_comb begin
        stall         = acc_sub;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = 32'd0;
        mem_writeData = 32'd0;
        if (state == ST_RMW_WR) begin
            mem_write     = 1'b1;
            mem_address   = merge_addr;
            mem_writeData = merge_word;
        end else if (acc_load || acc_sub) begin
            mem_read    = 1'b1;
            mem_address = word_idx;
        end else if (acc_sw) begin
            mem_write     = 1'b1;
            mem_address   = word_idx;
            mem_writeData = store_word;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            merge_word <= 32'd0;
            merge_addr <= 32'd0;
            load_valid <= 1'b0;
            load_data  <= 32'd0;
            load_rd    <= 5'd0;
            fault      <= 1'b0;
        end else begin
            load_valid <= acc_load;
            load_data  <= acc_load ? load_val : 32'd0;
            load_rd    <= acc_load ? req_rd : 5'd0;
            fault      <= fault_c;
            case (state)
                ST_IDLE: begin
                    if (acc_sub) begin
                        state      <= ST_RMW_WR;
                        merge_word <= store_word;
                        merge_addr <= word_idx;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    merge_word <= 32'd0;
                    merge_addr <= 32'd0;
                end
            endcase
        end
    end

endmodule
